// File: rtl/gptp_pkg.sv
// gptp_pkg
// Shared constants, types and helpers for the gPTP MAC-side datapath.
// Holds the Ethernet/PTP framing constants, frame geometry, the egress FSM
// state encoding and the PTP messageType codes.
package gptp_pkg;

    localparam logic [15:0] PTP_ETHERTYPE = 16'h88F7;
    localparam logic [47:0] PTP_MCAST_MAC = 48'h0180C200000E;
    localparam logic [29:0] NS_PER_SEC    = 30'd1000000000;

    localparam int HDR_LEN   = 14;
    localparam int PTP_LEN   = 44;
    localparam int FRAME_LEN = 60;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2,
        ST_PAD  = 2'd3
    } egress_state_t;

    typedef enum logic [3:0] {
        MSG_SYNC               = 4'h0,
        MSG_DELAY_REQ          = 4'h1,
        MSG_PDELAY_REQ         = 4'h2,
        MSG_PDELAY_RESP        = 4'h3,
        MSG_FOLLOW_UP          = 4'h8,
        MSG_DELAY_RESP         = 4'h9,
        MSG_PDELAY_RESP_FOLLOW = 4'hA,
        MSG_ANNOUNCE           = 4'hB,
        MSG_SIGNALING          = 4'hC,
        MSG_MANAGEMENT         = 4'hD
    } ptp_msg_type_t;

    // Event messages (those that need a hardware timestamp) are types 0..3.
    function automatic logic is_event_msg(input logic [3:0] msg_type);
        return (msg_type[3:2] == 2'b00);
    endfunction

    // Byte idx (0..13) of the Ethernet header: dst MAC, src MAC, EtherType,
    // each most significant byte first.
    function automatic logic [7:0] hdr_byte(input logic [47:0] src_mac,
                                            input logic [5:0]  idx);
        logic [111:0] hdr;
        hdr = {PTP_MCAST_MAC, src_mac, PTP_ETHERTYPE} << {idx, 3'b000};
        return hdr[111:104];
    endfunction

endpackage

// File: rtl/gptp_ts_adj.sv
// gptp_ts_adj
// Timestamp capture / latency add / second-rollover normalisation pipeline.
// The RTC is sampled and the fixed latency added on the trigger edge; the
// next edge normalises the nanoseconds into [0, 1e9) and registers the
// result, so ts_vld pulses two cycles after the trigger cycle.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   trig                  capture strobe (one cycle)
//   rtc_ns/sec/epoch      free-running RTC fields (ns always < 1e9)
//   ts_vld                one-cycle result strobe
//   ts_data               {epoch[15:0], sec[31:0], ns[31:0]}, held between strobes
module gptp_ts_adj
    import gptp_pkg::*;
#(
    parameter logic [29:0] TX_LATENCY_NS = 30'd64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trig,
    input  logic [31:0] rtc_ns,
    input  logic [31:0] rtc_sec,
    input  logic [15:0] rtc_epoch,
    output logic        ts_vld,
    output logic [79:0] ts_data
);

    logic        a_vld_q, a_vld_d;
    logic [30:0] a_ns_sum_q, a_ns_sum_d;
    logic [47:0] a_secs_q, a_secs_d;
    logic        ts_vld_q, ts_vld_d;
    logic [79:0] ts_data_q, ts_data_d;
    logic [30:0] ns_norm;
    logic [47:0] secs_norm;

    // ns < 1e9 < 2^30, so the MSB of the RTC ns field never carries information.
    logic ns_msb_unused;
    assign ns_msb_unused = rtc_ns[31];

    always_comb begin
        a_vld_d    = trig;
        a_ns_sum_d = a_ns_sum_q;
        a_secs_d   = a_secs_q;
        if (trig) begin
            a_ns_sum_d = rtc_ns[30:0] + {1'b0, TX_LATENCY_NS};
            a_secs_d   = {rtc_epoch, rtc_sec};
        end

        // One subtraction suffices: ns + latency < 2e9.
        // {epoch,sec} is incremented as one 48-bit count so sec wraps into epoch.
        ns_norm   = a_ns_sum_q;
        secs_norm = a_secs_q;
        if (a_ns_sum_q >= {1'b0, NS_PER_SEC}) begin
            ns_norm   = a_ns_sum_q - {1'b0, NS_PER_SEC};
            secs_norm = a_secs_q + 48'd1;
        end

        ts_vld_d  = a_vld_q;
        ts_data_d = ts_data_q;
        if (a_vld_q) begin
            ts_data_d = {secs_norm, 1'b0, ns_norm};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_vld_q    <= 1'b0;
            a_ns_sum_q <= '0;
            a_secs_q   <= '0;
            ts_vld_q   <= 1'b0;
            ts_data_q  <= '0;
        end else begin
            a_vld_q    <= a_vld_d;
            a_ns_sum_q <= a_ns_sum_d;
            a_secs_q   <= a_secs_d;
            ts_vld_q   <= ts_vld_d;
            ts_data_q  <= ts_data_d;
        end
    end

    assign ts_vld  = ts_vld_q;
    assign ts_data = ts_data_q;

endmodule

// File: rtl/gptp_ts_egress.sv
// gptp_ts_egress
// Wraps a 44-byte PTP message from the gPTP transmitter in an Ethernet
// header, pads to 60 bytes and streams it bytewise to the MAC (the MAC adds
// the FCS). The RTC is captured on the first-byte handshake, the fixed PHY
// latency added, and the egress timestamp returned to the gPTP core.
// Build option: GPTP_TS_EVENT_ONLY_EN - when defined, only event messages
// (messageType 0..3) produce a timestamp; the frame is sent either way.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   gptp_ts_vaild/ready/data message input (data[351:344] is first on wire)
//   gptp_ts_rv_vaild/data    timestamp strobe and {epoch,sec,ns}
//   rtc_*_field              RTC inputs
//   m_axis_t*                byte stream to the MAC
//
// Handshake semantics (both interfaces): a transfer happens on a rising edge
// where valid & ready are both high. valid never depends on ready; once
// m_axis_tvalid is high it stays high with tdata/tlast unchanged until the
// transfer, and stays high from byte 0 through byte 59. gptp_ts_vaild seen
// while gptp_ts_ready is low is ignored; the source holds its data.
module gptp_ts_egress
    import gptp_pkg::*;
#(
    parameter logic [47:0] SRC_MAC       = 48'h00_0A_35_00_01_02,
    parameter logic [29:0] TX_LATENCY_NS = 30'd64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         gptp_ts_vaild,
    output logic         gptp_ts_ready,
    input  logic [351:0] gptp_ts_data,
    output logic         gptp_ts_rv_vaild,
    output logic [79:0]  gptp_ts_rv_data,
    input  logic [31:0]  rtc_nanosec_field,
    input  logic [31:0]  rtc_sec_field,
    input  logic [15:0]  rtc_epoch_field,
    output logic [7:0]   m_axis_tdata,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic         m_axis_tlast
);

    localparam logic [5:0] LAST_HDR  = 6'(HDR_LEN - 1);
    localparam logic [5:0] LAST_PAY  = 6'(HDR_LEN + PTP_LEN - 1);
    localparam logic [5:0] LAST_BYTE = 6'(FRAME_LEN - 1);

    egress_state_t state_q, state_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [351:0]  buf_q, buf_d;
    logic          ready_q, ready_d;
    logic          beat;
    logic          ts_trig;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;

        m_axis_tvalid = (state_q != ST_IDLE);
        m_axis_tlast  = m_axis_tvalid && (cnt_q == LAST_BYTE);
        m_axis_tdata  = 8'h00;
        beat          = m_axis_tvalid && m_axis_tready;

        unique case (state_q)
            ST_IDLE: begin
                if (gptp_ts_vaild && ready_q) begin
                    buf_d   = gptp_ts_data;
                    cnt_d   = 6'd0;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                m_axis_tdata = hdr_byte(SRC_MAC, cnt_q);
                if (beat && cnt_q == LAST_HDR) state_d = ST_PAY;
            end
            ST_PAY: begin
                // The buffer shifts one byte per transfer, so the next
                // payload byte is always in the top lane.
                m_axis_tdata = buf_q[351:344];
                if (beat) begin
                    buf_d = buf_q << 8;
                    if (cnt_q == LAST_PAY) state_d = ST_PAD;
                end
            end
            ST_PAD: begin
                if (beat && cnt_q == LAST_BYTE) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (beat) begin
            cnt_d = (cnt_q == LAST_BYTE) ? 6'd0 : cnt_q + 6'd1;
        end

        // Registered ready: high exactly while the FSM sits in IDLE.
        ready_d = (state_d == ST_IDLE);

        // Byte 0 is still in HDR, so the buffer is unshifted and the
        // messageType nibble is intact here.
        ts_trig = beat && (cnt_q == 6'd0);
`ifdef GPTP_TS_EVENT_ONLY_EN
        ts_trig = ts_trig && is_event_msg(buf_q[347:344]);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 6'd0;
            buf_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            ready_q <= ready_d;
        end
    end

    assign gptp_ts_ready = ready_q;

    gptp_ts_adj #(
        .TX_LATENCY_NS (TX_LATENCY_NS)
    ) u_ts_adj (
        .clk       (clk),
        .reset     (reset),
        .trig      (ts_trig),
        .rtc_ns    (rtc_nanosec_field),
        .rtc_sec   (rtc_sec_field),
        .rtc_epoch (rtc_epoch_field),
        .ts_vld    (gptp_ts_rv_vaild),
        .ts_data   (gptp_ts_rv_data)
    );

endmodule

// File: tb/tb_gptp_ts_egress.sv
module tb_gptp_ts_egress;

    localparam logic [47:0] SRC_MAC = 48'h000A35000102;
    localparam logic [29:0] TX_LAT  = 30'd64;

    logic         clk;
    logic         reset;
    logic         gptp_ts_vaild;
    logic         gptp_ts_ready;
    logic [351:0] gptp_ts_data;
    logic         gptp_ts_rv_vaild;
    logic [79:0]  gptp_ts_rv_data;
    logic [31:0]  rtc_nanosec_field;
    logic [31:0]  rtc_sec_field;
    logic [15:0]  rtc_epoch_field;
    logic [7:0]   m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;

    gptp_ts_egress #(
        .SRC_MAC       (SRC_MAC),
        .TX_LATENCY_NS (TX_LAT)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .gptp_ts_vaild     (gptp_ts_vaild),
        .gptp_ts_ready     (gptp_ts_ready),
        .gptp_ts_data      (gptp_ts_data),
        .gptp_ts_rv_vaild  (gptp_ts_rv_vaild),
        .gptp_ts_rv_data   (gptp_ts_rv_data),
        .rtc_nanosec_field (rtc_nanosec_field),
        .rtc_sec_field     (rtc_sec_field),
        .rtc_epoch_field   (rtc_epoch_field),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tready     (m_axis_tready),
        .m_axis_tlast      (m_axis_tlast)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    bit rst_at_edge = 1'b1;
    always @(posedge clk) rst_at_edge <= reset;

    // ---------------- scoreboard state ----------------
    logic [8:0]  byte_exp_q[$];   // {tlast, tdata}
    logic [79:0] ts_exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    int cyc = 0;
    int beat_idx = 0;
    int byte0_cyc = 0;
    int last_cyc = 0;
    bit in_frame = 0;
    bit last_seen = 0;
    bit prev_stall = 0;
    bit prev_accept = 0;
    bit prev_last = 0;
    logic [7:0]  prev_data = '0;
    logic [79:0] prev_rv_data = '0;

    int tr_mode = 0;
    bit tog = 0;
    int stall_cnt = 0;
    bit stall_used = 0;

    logic [351:0] msg;

    logic [7:0] hdr_ref [14] = '{8'h01, 8'h80, 8'hC2, 8'h00, 8'h00, 8'h0E,
                                 8'h00, 8'h0A, 8'h35, 8'h00, 8'h01, 8'h02,
                                 8'h88, 8'hF7};

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic flag_fail(input string nm, input string what);
        n_vec++;
        n_err++;
        $display("FAIL %s: %s (t=%0t)", nm, what, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] ref_byte(input logic [351:0] m, input int i);
        if (i < 14) return hdr_ref[i];
        if (i < 58) return m[351 - 8*(i-14) -: 8];
        return 8'h00;
    endfunction

    function automatic logic [79:0] ts_model(input logic [15:0] ep, input logic [31:0] sec,
                                             input logic [31:0] ns);
        logic [63:0] secs;
        logic [63:0] nsum;
        logic [47:0] s48;
        logic [31:0] n32;
        secs = {16'h0, ep, sec};
        nsum = 64'(ns) + 64'(TX_LAT);
        if (nsum >= 64'd1000000000) begin
            nsum = nsum - 64'd1000000000;
            secs = secs + 64'd1;
        end
        s48 = secs[47:0];
        n32 = nsum[31:0];
        return {s48, n32};
    endfunction

    function automatic logic [351:0] rand_msg(input logic [3:0] mtype);
        logic [351:0] m;
        for (int w = 0; w < 11; w++) m[w*32 +: 32] = $urandom;
        m[347:344] = mtype;
        return m;
    endfunction

    // ---------------- tready driver ----------------
    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (tr_mode)
                0: m_axis_tready = 1'b1;
                1: begin
                    if (!stall_used && m_axis_tvalid && beat_idx == 13) begin
                        stall_cnt  = 5;
                        stall_used = 1'b1;
                    end
                    if (stall_cnt > 0) begin
                        m_axis_tready = 1'b0;
                        stall_cnt--;
                    end else begin
                        tog = ~tog;
                        m_axis_tready = tog;
                    end
                end
                default: m_axis_tready = ($urandom_range(3, 0) != 0);
            endcase
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [8:0] e;
        cyc++;
        if (rst_at_edge) begin
            check("rst_outputs", {gptp_ts_ready, m_axis_tvalid, m_axis_tlast, m_axis_tdata, gptp_ts_rv_vaild}, '0);
            check("rst_rv_data", gptp_ts_rv_data, '0);
            beat_idx = 0; in_frame = 0; last_seen = 0; prev_stall = 0; prev_accept = 0;
            prev_rv_data = '0;
        end else begin
            if (prev_accept) check("ready_drop", gptp_ts_ready, 1'b0);
            if (prev_stall)
                check("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, prev_last, prev_data});
            else if (in_frame)
                check("no_bubble", m_axis_tvalid, 1'b1);
            if (last_seen) begin
                check("gap_ready", gptp_ts_ready, 1'b1);
                check("gap_idle", m_axis_tvalid, 1'b0);
                last_seen = 0;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (byte_exp_q.size() == 0) begin
                    flag_fail("unexp_beat", $sformatf("got byte %0h, required none", m_axis_tdata));
                end else begin
                    e = byte_exp_q.pop_front();
                    check($sformatf("beat%0d", beat_idx), {m_axis_tlast, m_axis_tdata}, e);
                end
                if (beat_idx == 0) byte0_cyc = cyc;
                in_frame = 1;
                beat_idx++;
                if (m_axis_tlast) begin
                    beat_idx = 0; in_frame = 0; last_seen = 1; last_cyc = cyc;
                end
            end
            if (gptp_ts_rv_vaild) begin
                if (ts_exp_q.size() == 0)
                    flag_fail("unexp_ts", $sformatf("got pulse %0h, required none", gptp_ts_rv_data));
                else
                    check("ts_data", gptp_ts_rv_data, ts_exp_q.pop_front());
                check("ts_latency", cyc, byte0_cyc + 2);
            end else begin
                check("ts_hold", gptp_ts_rv_data, prev_rv_data);
            end
            prev_accept  = gptp_ts_ready && gptp_ts_vaild;
            prev_stall   = m_axis_tvalid && !m_axis_tready;
            prev_last    = m_axis_tlast;
            prev_data    = m_axis_tdata;
            prev_rv_data = gptp_ts_rv_data;
        end
    end

    // ---------------- frame driver ----------------
    task automatic send_frame(input logic [351:0] m, input logic [15:0] ep, input logic [31:0] sec,
                              input logic [31:0] ns, input int abort_beat);
        bit exp_ts;
        bit ok;
        @(posedge clk);
        #1;
        rtc_epoch_field   = ep;
        rtc_sec_field     = sec;
        rtc_nanosec_field = ns;
        stall_used        = 1'b0;
        for (int i = 0; i < 60; i++) byte_exp_q.push_back({(i == 59), ref_byte(m, i)});
        exp_ts = 1'b1;
`ifdef GPTP_TS_EVENT_ONLY_EN
        exp_ts = (m[347:344] <= 4'h3);
`endif
        // Reset one cycle after byte 0 lands before the result stage.
        if (abort_beat >= 0 && abort_beat <= 1) exp_ts = 1'b0;
        if (exp_ts) ts_exp_q.push_back(ts_model(ep, sec, ns));

        gptp_ts_data  = m;
        gptp_ts_vaild = 1'b1;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = gptp_ts_ready;
        end
        if (!ok) begin
            flag_fail("accept_timeout", "got ready low, required high");
            gptp_ts_vaild = 1'b0;
            byte_exp_q.delete();
            ts_exp_q.delete();
            return;
        end
        @(posedge clk);
        #1;
        gptp_ts_vaild = 1'b0;
        gptp_ts_data  = rand_msg(4'(($urandom_range(15, 0))));

        if (abort_beat >= 0) begin
            ok = 0;
            for (int i = 0; i < 500 && !ok; i++) begin
                @(negedge clk);
                #1;
                ok = (beat_idx == abort_beat);
            end
            if (!ok) flag_fail("abort_wait", "got no such beat, required one");
            @(posedge clk);
            #1;
            reset = 1'b1;
            @(posedge clk);
            #1;
            byte_exp_q.delete();
            @(posedge clk);
            #1;
            reset = 1'b0;
            check("ts_after_abort", ts_exp_q.size(), 0);
            ts_exp_q.delete();
            return;
        end

        ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            #1;
            ok = (byte_exp_q.size() == 0);
        end
        if (!ok) begin
            flag_fail("frame_timeout", $sformatf("got %0d bytes missing, required 0", byte_exp_q.size()));
            byte_exp_q.delete();
        end
        repeat (3) @(negedge clk);
        #1;
        check("ts_outstanding", ts_exp_q.size(), 0);
        ts_exp_q.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] ep;
        logic [31:0] sec;
        logic [31:0] ns;
        reset             = 1'b1;
        gptp_ts_vaild     = 1'b0;
        gptp_ts_data      = '0;
        rtc_nanosec_field = '0;
        rtc_sec_field     = '0;
        rtc_epoch_field   = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Incrementing payload, timestamp without rollover.
        tr_mode = 0;
        for (int i = 0; i < 44; i++) msg[351 - 8*i -: 8] = 8'(i);
        send_frame(msg, 16'd0, 32'd5, 32'd100, -1);

        // Rollover of ns into sec and sec into epoch.
        send_frame(rand_msg(4'h0), 16'd7, 32'hFFFFFFFF, 32'd999_999_990, -1);

        // Alternating tready with a 5-cycle stall on byte 13.
        tr_mode = 1;
        send_frame(rand_msg(4'h2), 16'h1234, 32'hDEAD0001, 32'd500, -1);

        // Reset in the payload, then right after byte 0.
        tr_mode = 0;
        send_frame(rand_msg(4'h0), 16'd1, 32'd2, 32'd3, 30);
        send_frame(rand_msg(4'h1), 16'd4, 32'd5, 32'd6, 1);

        // Clean frame after the aborts.
        for (int i = 0; i < 44; i++) msg[351 - 8*i -: 8] = 8'(8'hA0 + i);
        send_frame(msg, 16'd9, 32'd10, 32'd999_999_936, -1);

        // Announce (general) and Sync (event).
        send_frame(rand_msg(4'hB), 16'd2, 32'd77, 32'd1000, -1);
        send_frame(rand_msg(4'h0), 16'd2, 32'd78, 32'd2000, -1);

        // Randomised frames with random backpressure.
        tr_mode = 2;
        for (int f = 0; f < 10; f++) begin
            ep  = 16'($urandom);
            sec = ($urandom_range(3, 0) == 0) ? 32'hFFFFFFFF : $urandom;
            ns  = ($urandom_range(1, 0) == 1) ? 32'($urandom_range(999_999_999, 999_999_900))
                                              : 32'($urandom_range(999_999_999, 0));
            send_frame(rand_msg(4'(($urandom_range(15, 0)))), ep, sec, ns, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/gptp_ts_egress.md
Name: gptp_ts_egress

Overview:
- MAC-side counterpart of the gPTP transmit path.
- Accepts a 352-bit (44-byte) PTP message from the gPTP transmitter and prepends the 14-byte Ethernet header. Pads the frame to 60 bytes and streams it bytewise to the MAC; the MAC appends the FCS.
- Captures the RTC at first-byte handshake, compensates for fixed PHY latency, and returns an 80-bit egress timestamp to the gPTP core.

Parameters:
- SRC_MAC, 48'h00_0A_35_00_01_02, source MAC placed in header bytes 6..11.
- TX_LATENCY_NS, 30'd64, fixed egress latency added to the captured nanoseconds; must be < 10^9.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- gptp_ts_vaild  in  1  PTP message valid.
- gptp_ts_ready  out  1  block can accept a message.
- gptp_ts_data  in  352  PTP message; [351:344] is the first byte on the wire.
- gptp_ts_rv_vaild  out  1  one-cycle pulse; timestamp valid.
- gptp_ts_rv_data  out  80  {epoch[15:0], sec[31:0], ns[31:0]}.
- rtc_nanosec_field  in  32  RTC nanoseconds, always < 10^9.
- rtc_sec_field  in  32  RTC seconds.
- rtc_epoch_field  in  16  RTC epoch, the upper 16 bits of the seconds count.
- m_axis_tdata  out  8  byte to MAC.
- m_axis_tvalid  out  1  byte valid.
- m_axis_tready  in  1  MAC accepts byte.
- m_axis_tlast  out  1  last byte of frame (byte 59).

Behaviour:
- Reset values: all outputs 0, including gptp_ts_ready. State goes to IDLE. gptp_ts_ready rises the first cycle after reset deasserts.
- Accept: a message is taken on gptp_ts_vaild & gptp_ts_ready. On that cycle:
  - gptp_ts_data is latched into a 352-bit buffer.
  - gptp_ts_ready drops on the next cycle.
  - State moves IDLE->HDR.
- gptp_ts_ready is registered. It is 1 only in IDLE.
- Minimum gap between the tlast handshake and the next accept is 1 cycle.
- FSM: IDLE -> HDR (bytes 0..13) -> PAY (bytes 14..57) -> PAD (bytes 58..59) -> IDLE.
  - A 6-bit byte counter advances only on tvalid & tready.
  - tlast=1 exactly while counter==59.
  - The IDLE transition happens on the byte-59 handshake.
- Header bytes:
  - 0..5: 01-80-C2-00-00-0E.
  - 6..11: SRC_MAC, MSB first.
  - 12..13: 88 F7.
- Payload bytes: taken from the buffer MSB first. Pad bytes are 00.
- AXIS rules:
  - tvalid stays high from byte 0 through byte 59 without bubbles.
  - tdata and tlast are stable while tvalid & !tready.
  - No dependence of tvalid on tready.
- Timestamp pipeline (sub-module), triggered by the byte-0 handshake:
  - S0: capture {epoch, sec, ns} from the RTC inputs on the handshake cycle.
  - S1: ns_sum = ns + TX_LATENCY_NS, computed at 31-bit width.
  - S2: if ns_sum >= 10^9, then ns = ns_sum - 10^9 and {epoch,sec} += 1, with sec 0xFFFFFFFF carrying into epoch. The result is registered to gptp_ts_rv_data, and gptp_ts_rv_vaild is pulsed.
  - gptp_ts_rv_vaild pulses exactly 2 cycles after the byte-0 handshake. This is independent of the rest of the frame streaming.
  - gptp_ts_rv_data holds its value until the next pulse.
- At most one frame is in flight, so pipeline overlap cannot occur.
- Reset mid-frame:
  - Next edge forces tvalid=0, tlast=0 and IDLE.
  - Any pending timestamp is discarded (no pulse).
  - The MAC sees a truncated frame without tlast; the MAC is required to drop it.
- gptp_ts_vaild asserted while not ready is ignored. The source holds data until ready.

Optional Feature:
- Macro: GPTP_TS_EVENT_ONLY_EN.
- Defined: a timestamp is returned only for event messages, i.e. messageType = gptp_ts_data[347:344] in {0x0,0x1,0x2,0x3}. For other types the S0 capture is suppressed and gptp_ts_rv_vaild stays 0. Frame transmission is unchanged.
- Undefined: a timestamp is returned for every frame.

Decomposition:
- Package gptp_pkg holds:
  - constants PTP_ETHERTYPE=16'h88F7, PTP_MCAST_MAC=48'h0180C200000E, NS_PER_SEC=30'd1000000000;
  - HDR_LEN=14, PTP_LEN=44, FRAME_LEN=60;
  - the egress FSM state enum;
  - the messageType codes.
- Sub-module gptp_ts_adj implements the 3-stage capture/add/normalize pipeline. It is reusable by the ingress path.

Test Plan:
- Single frame, tready=1, payload bytes 0x00..0x2B:
  - stream is 60 beats: header, then 00..2B, then 00 00;
  - tlast only on beat 60;
  - gptp_ts_ready back high 1 cycle after tlast.
- Timestamp without wrap, RTC ns=100, sec=5, epoch=0 at byte 0, TX_LATENCY_NS=64 -> 2 cycles later a pulse with data {0,5,164}.
- Wrap: ns=999_999_990, sec=0xFFFFFFFF, epoch=7 -> {8, 0, 54}.
- Backpressure: tready toggles 1010... and is held low for 5 cycles at byte 13 -> tdata/tlast stable while stalled; no byte lost or duplicated; exactly 60 handshakes.
- Reset asserted at byte 30:
  - tvalid=0 next cycle;
  - no ts pulse if reset lands within 2 cycles of byte 0;
  - next frame streams correctly from byte 0.
- With GPTP_TS_EVENT_ONLY_EN, messageType 0xB (Announce) -> frame sent, no gptp_ts_rv_vaild. With messageType 0x0 (Sync) -> pulse present.
